// File: rtl/spi_jtag_pkg.sv
// Shared types and field layout for the JTAG USER-register to SPI flash bridge.
// The header is 8 bits: channel in the low bits, CS-hold flag in the MSB.
package spi_jtag_pkg;

    localparam int unsigned HDR_W     = 8;
    localparam int unsigned CH_BITS   = 3;
    localparam int unsigned HOLD_BIT  = 7;
    localparam int unsigned LEN_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLen,
        StPayload,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/spi_rd_delay_line.sv
// Fixed-length 1-bit delay line re-aligning flash MISO with the TDO sampling point.
// A DEPTH of 0 is a plain wire.
module spi_rd_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;
        logic [DEPTH:0]   ext;

        assign ext  = {sr_q, din};
        assign dout = sr_q[DEPTH-1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q <= ext[DEPTH-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_jtag_bridge.sv
// JTAG DR-scan to SPI bridge: parses header and bit count, gates SCK for the payload,
// drives one chip select and returns delayed MISO on TDO.
module spi_jtag_bridge
    import spi_jtag_pkg::*;
#(
    parameter int unsigned NUM_CS   = 2,
    parameter int unsigned RD_DELAY = 1,
    parameter int unsigned LEN_W    = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tap_sel,
    input  logic              tap_capture,
    input  logic              tap_shift,
    input  logic              tap_update,
    input  logic              tap_runtest,
    input  logic              tap_tdi,
    output logic              tap_tdo,
    output logic              spi_sck_en,
    output logic              spi_mosi,
    input  logic [NUM_CS-1:0] spi_miso,
    output logic [NUM_CS-1:0] spi_csn,
    output logic              xfer_done,
    output logic              xfer_err
);

    localparam logic [LEN_W-1:0] HDR_LAST   = LEN_W'(HDR_W - 1);
    localparam logic [LEN_W-1:0] LEN_LAST   = LEN_W'(LEN_W - 1);
    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(RD_DELAY - 1);

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [HDR_W-1:0]     hdr_q, hdr_d, hdr_next;
    logic [LEN_W-1:0]     len_q, len_d, len_next;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic                 hold_q, hold_d, ch_ok_q, ch_ok_d, new_ok;
    logic [NUM_CS-1:0]    csn_q, csn_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 bit_en, cap, upd, miso_sel, miso_dly;

    assign bit_en   = tap_sel & tap_shift;
    assign cap      = tap_sel & tap_capture;
    assign upd      = tap_sel & tap_update;
    assign hdr_next = {tap_tdi, hdr_q[HDR_W-1:1]};
    assign len_next = {tap_tdi, len_q[LEN_W-1:1]};
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign new_ok   = 32'(hdr_next[CH_BITS-1:0]) < NUM_CS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        ch_d    = ch_q;
        hold_d  = hold_q;
        ch_ok_d = ch_ok_q;
        csn_d   = csn_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (tap_runtest) begin
            state_d = StIdle;
            cnt_d   = '0;
            hold_d  = 1'b0;
            csn_d   = '1;
        end else begin
            // Update is resolved before a same-cycle capture; a held CS survives only in DONE.
            if (upd && state_q != StDone) begin
                csn_d   = '1;
                state_d = StIdle;
                err_d   = (state_q != StIdle);
            end
            if (cap) begin
                state_d = StHdr;
                cnt_d   = '0;
            end else if (!upd && bit_en) begin
                case (state_q)
                    StHdr: begin
                        hdr_d = hdr_next;
                        if (cnt_q == HDR_LAST) begin
                            state_d = StLen;
                            cnt_d   = '0;
                            ch_d    = hdr_next[CH_BITS-1:0];
                            hold_d  = hdr_next[HOLD_BIT];
                            ch_ok_d = new_ok;
                            err_d   = !new_ok;
                            for (int i = 0; i < NUM_CS; i++) begin
                                if (!(new_ok && hdr_next[CH_BITS-1:0] == CH_BITS'(i))) begin
                                    csn_d[i] = 1'b1;
                                end
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    StLen: begin
                        len_d = len_next;
                        if (cnt_q == LEN_LAST) begin
                            cnt_d = '0;
                            if (len_next == '0) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                                if (!hold_q) csn_d = '1;
                            end else begin
                                state_d = StPayload;
                                for (int i = 0; i < NUM_CS; i++) begin
                                    if (ch_ok_q && ch_q == CH_BITS'(i)) csn_d[i] = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    StPayload: begin
                        if (cnt_q == len_q - 1'b1) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                            if (RD_DELAY > 0) begin
                                state_d = StDrain;
                            end else begin
                                state_d = StDone;
                                if (!hold_q) csn_d = '1;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    StDrain: begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_d = StDone;
                            cnt_d   = '0;
                            if (!hold_q) csn_d = '1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    StDone:  cnt_d = cnt_inc;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hdr_q   <= '0;
            len_q   <= '0;
            ch_q    <= '0;
            hold_q  <= 1'b0;
            ch_ok_q <= 1'b0;
            csn_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            ch_q    <= ch_d;
            hold_q  <= hold_d;
            ch_ok_q <= ch_ok_d;
            csn_q   <= csn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        miso_sel = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (ch_ok_q && ch_q == CH_BITS'(i)) miso_sel = spi_miso[i];
        end
    end

    spi_rd_delay_line #(
        .DEPTH(RD_DELAY)
    ) u_rd_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (miso_sel),
        .dout (miso_dly)
    );

    always_comb begin
        case (state_q)
            StHdr, StLen:       tap_tdo = tap_tdi;
            StPayload, StDrain: tap_tdo = miso_dly;
            default:            tap_tdo = 1'b0;
        endcase
    end

    assign spi_sck_en = bit_en & (state_q == StPayload);
    assign spi_mosi   = (state_q == StPayload) ? tap_tdi : 1'b0;
    assign spi_csn    = csn_q;
    assign xfer_done  = done_q;
    assign xfer_err   = err_q;

endmodule

// File: tb/tb_spi_jtag_bridge.sv
// Directed bench for spi_jtag_bridge (NUM_CS=2, RD_DELAY=1, LEN_W=16).
module tb_spi_jtag_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tap_sel = 1'b1;
    logic       tap_capture = 1'b0, tap_shift = 1'b0, tap_update = 1'b0, tap_runtest = 1'b0;
    logic       tap_tdi = 1'b0;
    logic       tap_tdo, spi_sck_en, spi_mosi, xfer_done, xfer_err;
    logic [1:0] spi_miso = 2'b00;
    logic [1:0] spi_csn;

    int total = 0;
    int bad = 0;

    logic       s_sck, s_mosi, s_tdo, a_done, a_err;
    logic [1:0] s_csn, a_csn;
    logic       r_sck [64];
    logic       r_mosi[64];
    logic       r_tdo [64];
    logic       r_done[64];
    logic       r_err [64];
    logic [1:0] r_csn [64];

    spi_jtag_bridge #(
        .NUM_CS  (2),
        .RD_DELAY(1),
        .LEN_W   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tap_sel    (tap_sel),
        .tap_capture(tap_capture),
        .tap_shift  (tap_shift),
        .tap_update (tap_update),
        .tap_runtest(tap_runtest),
        .tap_tdi    (tap_tdi),
        .tap_tdo    (tap_tdo),
        .spi_sck_en (spi_sck_en),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_csn    (spi_csn),
        .xfer_done  (xfer_done),
        .xfer_err   (xfer_err)
    );

    always #5 clk = ~clk;

    // Drive at negedge, sample combinational outputs mid-cycle, registered ones after posedge.
    task automatic cycle(input logic cap, input logic sh, input logic upd, input logic rt,
                         input logic tdi, input logic [1:0] miso, input logic rstn);
        @(negedge clk);
        tap_capture = cap;
        tap_shift   = sh;
        tap_update  = upd;
        tap_runtest = rt;
        tap_tdi     = tdi;
        spi_miso    = miso;
        rst_n       = rstn;
        #1;
        s_sck  = spi_sck_en;
        s_mosi = spi_mosi;
        s_tdo  = tap_tdo;
        s_csn  = spi_csn;
        @(posedge clk);
        #1;
        a_csn  = spi_csn;
        a_done = xfer_done;
        a_err  = xfer_err;
    endtask

    // mode 0: miso[0]=pat, 1: miso[1]=pat (other channel inverted), 2: both = pat
    task automatic scan(input logic [63:0] bits, input int n, input logic [63:0] pat,
                        input int mode);
        logic [1:0] mv;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < n; i++) begin
            mv = (mode == 0) ? {~pat[i], pat[i]} : (mode == 1) ? {pat[i], ~pat[i]} : {2{pat[i]}};
            cycle(1'b0, 1'b1, 1'b0, 1'b0, bits[i], mv, 1'b1);
            r_sck[i]  = s_sck;
            r_mosi[i] = s_mosi;
            r_tdo[i]  = s_tdo;
            r_csn[i]  = s_csn;
            r_done[i] = a_done;
            r_err[i]  = a_err;
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] h, input logic [15:0] l,
                                       input logic [15:0] p);
        mk = {24'b0, p, l, h};
    endfunction

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        total++;
        if ({s_csn, s_tdo, s_sck, s_mosi, a_done, a_err} !== 7'b11_00000) begin
            bad++;
            $display("FAIL reset: csn/tdo/sck/mosi/done/err got %b %b %b %b %b %b need 11 0 0 0 0 0",
                     s_csn, s_tdo, s_sck, s_mosi, a_done, a_err);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_basic();
        logic [63:0] bits = mk(8'h01, 16'd8, 16'h009F);
        logic [63:0] pat  = 64'hA5 << 24;
        logic [7:0]  mo, to;
        logic [23:0] echo;
        int          nsck = 0, ndone = 0;
        scan(bits, 35, pat, 1);
        for (int i = 0; i < 35; i++) begin
            nsck  += int'(r_sck[i]);
            ndone += int'(r_done[i]);
        end
        for (int k = 0; k < 8; k++) begin
            mo[k] = r_mosi[24+k];
            to[k] = r_tdo[25+k];
        end
        for (int k = 0; k < 24; k++) echo[k] = r_tdo[k];
        total++;
        if (nsck !== 8) begin bad++; $display("FAIL basic_sck_count: got %0d need 8", nsck); end
        total++;
        if ({r_sck[23], r_sck[24], r_sck[31], r_sck[32]} !== 4'b0110) begin
            bad++; $display("FAIL basic_sck_window: got %b%b%b%b need 0110",
                            r_sck[23], r_sck[24], r_sck[31], r_sck[32]);
        end
        total++;
        if (mo !== 8'h9F) begin bad++; $display("FAIL basic_mosi: got %h need 9f", mo); end
        total++;
        if (echo !== bits[23:0]) begin
            bad++; $display("FAIL basic_echo: got %h need %h", echo, bits[23:0]);
        end
        total++;
        if (to !== 8'hA5) begin bad++; $display("FAIL basic_tdo_miso: got %h need a5", to); end
        total++;
        if ({r_csn[23], r_csn[24], r_csn[31], r_csn[33]} !== 8'b11_01_01_11) begin
            bad++; $display("FAIL basic_csn: got %b %b %b %b need 11 01 01 11",
                            r_csn[23], r_csn[24], r_csn[31], r_csn[33]);
        end
        total++;
        if (ndone !== 1 || r_done[31] !== 1'b1) begin
            bad++; $display("FAIL basic_done: count %0d at31 %b need 1 1", ndone, r_done[31]);
        end
        total++;
        if ({r_tdo[33], r_sck[33], r_tdo[34], r_sck[34]} !== 4'b0000) begin
            bad++; $display("FAIL basic_done_extra: got %b%b%b%b need 0000",
                            r_tdo[33], r_sck[33], r_tdo[34], r_sck[34]);
        end
    endtask

    task automatic test_zero_len();
        int nsck = 0, nlow = 0;
        scan(mk(8'h00, 16'd0, 16'h0), 26, 64'h0, 0);
        for (int i = 0; i < 26; i++) begin
            nsck += int'(r_sck[i]);
            nlow += int'(r_csn[i] != 2'b11);
        end
        total++;
        if (nsck !== 0 || nlow !== 0) begin
            bad++; $display("FAIL zero_len_idle: sck %0d cs_low %0d need 0 0", nsck, nlow);
        end
        total++;
        if ({r_done[22], r_done[23], r_done[24]} !== 3'b010) begin
            bad++; $display("FAIL zero_len_done: got %b%b%b need 010",
                            r_done[22], r_done[23], r_done[24]);
        end
    endtask

    task automatic test_hold();
        int nlow = 0;
        scan(mk(8'h80, 16'd8, 16'h0055), 33, 64'h0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        total++;
        if (a_csn !== 2'b10) begin
            bad++; $display("FAIL hold_after_update: got %b need 10", a_csn);
        end
        scan(mk(8'h00, 16'd16, 16'h1234), 42, 64'h0, 0);
        for (int i = 0; i < 41; i++) nlow += int'(r_csn[i] == 2'b10);
        total++;
        if (nlow !== 41) begin bad++; $display("FAIL hold_second_scan: low %0d need 41", nlow); end
        total++;
        if (r_csn[41] !== 2'b11) begin
            bad++; $display("FAIL hold_release: got %b need 11", r_csn[41]);
        end
    endtask

    task automatic test_hold_switch();
        scan(mk(8'h80, 16'd8, 16'h00FF), 33, 64'h0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        scan(mk(8'h01, 16'd8, 16'h00C3), 34, 64'h0, 1);
        total++;
        if ({r_csn[7], r_csn[8], r_csn[24], r_csn[31], r_csn[33]} !== 10'b10_11_01_01_11) begin
            bad++; $display("FAIL hold_switch_csn: got %b %b %b %b %b need 10 11 01 01 11",
                            r_csn[7], r_csn[8], r_csn[24], r_csn[31], r_csn[33]);
        end
    endtask

    task automatic test_bad_channel();
        int nsck = 0, nlow = 0, ntdo = 0, nerr = 0;
        scan(mk(8'h05, 16'd8, 16'h00AA), 34, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        for (int i = 0; i < 34; i++) begin
            nsck += int'(r_sck[i]);
            nlow += int'(r_csn[i] != 2'b11);
            nerr += int'(r_err[i]);
        end
        for (int i = 24; i < 34; i++) ntdo += int'(r_tdo[i]);
        total++;
        if (nerr !== 1 || r_err[7] !== 1'b1) begin
            bad++; $display("FAIL bad_ch_err: count %0d at7 %b need 1 1", nerr, r_err[7]);
        end
        total++;
        if (nlow !== 0 || nsck !== 8 || ntdo !== 0) begin
            bad++; $display("FAIL bad_ch_io: cs_low %0d sck %0d tdo_ones %0d need 0 8 0",
                            nlow, nsck, ntdo);
        end
    endtask

    task automatic test_abort();
        scan(mk(8'h00, 16'd8, 16'h00F0), 27, 64'h0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        total++;
        if ({r_csn[26], a_csn, a_err} !== 5'b10_11_1) begin
            bad++; $display("FAIL abort_update: csn %b->%b err %b need 10->11 1",
                            r_csn[26], a_csn, a_err);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        total++;
        if ({s_sck, s_tdo, s_mosi} !== 3'b000) begin
            bad++; $display("FAIL abort_update_idle: sck/tdo/mosi %b%b%b need 000",
                            s_sck, s_tdo, s_mosi);
        end
        scan(mk(8'h80, 16'd8, 16'h00F0), 26, 64'h0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        total++;
        if ({a_csn, a_err} !== 3'b11_0) begin
            bad++; $display("FAIL abort_reset: csn %b err %b need 11 0", a_csn, a_err);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        total++;
        if ({s_sck, s_tdo} !== 2'b00) begin
            bad++; $display("FAIL abort_reset_idle: sck/tdo %b%b need 00", s_sck, s_tdo);
        end
        scan(mk(8'h80, 16'd8, 16'h00F0), 33, 64'h0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        total++;
        if ({r_csn[32], a_csn, a_err} !== 5'b10_11_0) begin
            bad++; $display("FAIL abort_runtest: csn %b->%b err %b need 10->11 0",
                            r_csn[32], a_csn, a_err);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        total++;
        if ({s_sck, s_csn} !== 3'b0_11) begin
            bad++; $display("FAIL abort_runtest_idle: sck %b csn %b need 0 11", s_sck, s_csn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_hold();
        test_hold_switch();
        test_bad_channel();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
